// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter.
// Runs inhibit, request-to-send, shifts data/parity/stop on device clock edges, then checks the ACK.
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES       = 5000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int XFER_TIMEOUT_CYCLES  = 100000
) (
  input  logic       clk50m_i,
  input  logic       rst_i,
  input  logic [7:0] cmd_data_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  output logic       busy_o,
  output logic       tx_done_o,
  output logic       tx_error_o,
  output logic [1:0] error_code_o
);

  localparam int TO_MAX    = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ?
                             START_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
  localparam int TIMER_MAX = (TO_MAX > INHIBIT_CYCLES) ? TO_MAX : INHIBIT_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX + 1);

  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] XFER_LAST    = TW'(XFER_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_SAT    = TW'(TIMER_MAX);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, WAIT_CLK, SHIFT, ACK_WAIT, ERR
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next, timer_inc;
  logic [3:0]    edge_cnt_reg, edge_cnt_next, edge_num;
  logic [7:0]    byte_reg, byte_next;
  logic          parity_reg, parity_next;
  logic          drive_reg, drive_next;
  logic [1:0]    code_reg, code_next;
  logic          done_reg, done_next;
  logic          error_reg, error_next;

  logic clk_meta_reg, clk_sync_reg, clk_prev_reg;
  logic data_meta_reg, data_sync_reg;
  logic fe;

  // Synchronizers idle at 1 so a released bus never looks like an edge after reset.
  always_ff @(posedge clk50m_i or posedge rst_i) begin
    if (rst_i) begin
      clk_meta_reg  <= 1'b1;
      clk_sync_reg  <= 1'b1;
      clk_prev_reg  <= 1'b1;
      data_meta_reg <= 1'b1;
      data_sync_reg <= 1'b1;
    end else begin
      clk_meta_reg  <= ps2_clk_i;
      clk_sync_reg  <= clk_meta_reg;
      clk_prev_reg  <= clk_sync_reg;
      data_meta_reg <= ps2_data_i;
      data_sync_reg <= data_meta_reg;
    end
  end

  assign fe        = clk_prev_reg & ~clk_sync_reg;
  assign timer_inc = (timer_reg == TIMER_SAT) ? timer_reg : timer_reg + TW'(1);
  assign edge_num  = edge_cnt_reg + 4'd1;

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    edge_cnt_next = edge_cnt_reg;
    byte_next     = byte_reg;
    parity_next   = parity_reg;
    drive_next    = drive_reg;
    code_next     = code_reg;
    done_next     = 1'b0;
    error_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid_i) begin
          byte_next     = cmd_data_i;
          parity_next   = ~^cmd_data_i;
          edge_cnt_next = 4'd0;
          code_next     = 2'b00;
          timer_next    = '0;
          state_next    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (timer_reg == INHIBIT_LAST) begin
          timer_next = '0;
          state_next = REQ;
        end else begin
          timer_next = timer_inc;
        end
      end
      REQ: begin
        timer_next = '0;
        state_next = WAIT_CLK;
      end
      WAIT_CLK: begin
        if (fe) begin
          edge_cnt_next = 4'd1;
          drive_next    = ~byte_reg[0];
          timer_next    = TW'(1);
          state_next    = SHIFT;
        end else if (timer_reg >= START_LAST) begin
          code_next  = 2'b01;
          error_next = 1'b1;
          state_next = ERR;
        end else begin
          timer_next = timer_inc;
        end
      end
      SHIFT: begin
        // An edge in the same cycle as the timeout is still honoured.
        if (fe) begin
          edge_cnt_next = edge_num;
          timer_next    = timer_inc;
          if (edge_num <= 4'd8) begin
            drive_next = ~byte_reg[edge_cnt_reg[2:0]];
          end else if (edge_num == 4'd9) begin
            drive_next = ~parity_reg;
          end else if (edge_num == 4'd10) begin
            drive_next = 1'b0;
          end else if (data_sync_reg) begin
            code_next  = 2'b11;
            error_next = 1'b1;
            state_next = ERR;
          end else begin
            state_next = ACK_WAIT;
          end
        end else if (timer_reg >= XFER_LAST) begin
          code_next  = 2'b10;
          error_next = 1'b1;
          state_next = ERR;
        end else begin
          timer_next = timer_inc;
        end
      end
      ACK_WAIT: begin
        if (clk_sync_reg && data_sync_reg) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (timer_reg >= XFER_LAST) begin
          code_next  = 2'b10;
          error_next = 1'b1;
          state_next = ERR;
        end else begin
          timer_next = timer_inc;
        end
      end
      ERR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50m_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      edge_cnt_reg <= 4'd0;
      byte_reg     <= 8'h00;
      parity_reg   <= 1'b0;
      drive_reg    <= 1'b0;
      code_reg     <= 2'b00;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      edge_cnt_reg <= edge_cnt_next;
      byte_reg     <= byte_next;
      parity_reg   <= parity_next;
      drive_reg    <= drive_next;
      code_reg     <= code_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
    end
  end

  // Pad enables decode straight from state so an async reset releases both at once.
  assign ps2_clk_oe_o  = (state_reg == INHIBIT) || (state_reg == REQ);
  assign ps2_data_oe_o = (state_reg == REQ) || (state_reg == WAIT_CLK) ||
                         ((state_reg == SHIFT) && drive_reg);
  assign cmd_ready_o   = (state_reg == IDLE);
  assign busy_o        = (state_reg != IDLE);
  assign tx_done_o     = done_reg;
  assign tx_error_o    = error_reg;
  assign error_code_o  = code_reg;

endmodule
